ip_send: RTL and testbench
==========================

// Module: ip_send
// PURPOSE
//  Transmit-side IPv4 layer: on a start pulse, builds a 20-byte IPv4 header with a computed checksum.
//  Streams the header, then the caller's payload bytes, to the Ethernet MAC tx path, one byte per clock.
//  Sits between the UDP/ICMP senders and the MAC framer.
// PARAMETERS
//  TTL       8'd128   time-to-live, header byte 8
//  TOS       8'd0     type-of-service, header byte 1
//  MAX_PAY   11'd1480 largest accepted payload_len
// PORTS
//  clock         in   1   system clock, all logic on rising edge
//  reset         in   1   synchronous, active-high
//  tx_start      in   1   one-cycle request; latches is_icmp, payload_len, local_ip, remote_ip
//  is_icmp       in   1   1: protocol 0x01, 0: protocol 0x11 (UDP)
//  payload_len   in   11  payload bytes following the header
//  local_ip      in   32  source address
//  remote_ip     in   32  destination address
//  tx_ready      in   1   MAC accepts a byte this cycle
//  payload_data  in   8   payload byte from the upstream sender
//  payload_rd    out  1   payload_data is consumed this cycle
//  data_out      out  8   byte to the MAC
//  out_valid     out  1   data_out is valid; the byte is transferred when out_valid & tx_ready
//  busy          out  1   packet in progress; tx_start is ignored while high
//  len_err       out  1   one-cycle pulse: tx_start rejected because payload_len > MAX_PAY
// BEHAVIOUR
//  Reset:
//  - State goes to ST_IDLE; busy, out_valid, payload_rd, len_err are 0; data_out is 8'h00; ident is 16'h0000.
//  - Reset mid-packet aborts immediately; the remaining bytes are never emitted.
//  States: ST_IDLE -> ST_CSUM -> ST_HEADER -> ST_PAYLOAD -> ST_IDLE.
//  ST_IDLE:
//  - tx_start with payload_len <= MAX_PAY latches the inputs, sets busy the next cycle, and enters ST_CSUM.
//  - tx_start with payload_len > MAX_PAY pulses len_err the next cycle and stays in ST_IDLE.
//  ST_CSUM:
//  - Cycles 1..10: add the 10 header 16-bit words into a 20-bit accumulator, with the checksum word as 0.
//  - Cycle 11: fold, sum[15:0] + sum[19:16].
//  - Cycle 12: fold again and invert.
//  - First header byte: out_valid rises 13 cycles after the tx_start edge.
//  ST_HEADER, 20 bytes, index advances only on out_valid & tx_ready:
//  - 0: 0x45
//  - 1: TOS
//  - 2-3: total length = 20 + payload_len (16-bit, MSB first)
//  - 4-5: ident
//  - 6: flags (see CONFIGURATION)
//  - 7: 0x00
//  - 8: TTL
//  - 9: protocol
//  - 10-11: checksum
//  - 12-15: local_ip, MSB first
//  - 16-19: remote_ip, MSB first
//  - After byte 19: go to ST_PAYLOAD, or to ST_IDLE if payload_len == 0.
//  ST_PAYLOAD:
//  - payload_rd = tx_ready (combinational); data_out = payload_data; out_valid = 1.
//  - Byte counter increments on each transfer.
//  - The transfer of byte payload_len returns the block to ST_IDLE; busy falls the following cycle.
//  tx_ready low: index, counter and data_out hold; payload_rd stays 0. Applies in any state.
//  ident increments by 1 (wraps 16'hFFFF -> 0) when the last byte of a packet transfers; it is not
//   incremented on an aborted packet.
//  tx_start while busy: ignored, with no effect on the packet in flight.
//  tx_start in the cycle busy falls is accepted.
// CONFIGURATION
//  IP_SEND_DF_EN
//  - Defined: byte 6 = 0x40 (Don't Fragment), and it is included in the checksum.
//  - Undefined: byte 6 = 0x00.
// TESTING
//  1 UDP, local C0A8010A, remote C0A80114, payload_len 8, ident 0, DF off, tx_ready=1
//    -> bytes 45 00 00 1C 00 00 00 00 80 11 B7 62 C0 A8 01 0A C0 A8 01 14, then 8 payload bytes.
//    -> First byte 13 cycles after tx_start.
//  2 Same stimulus with IP_SEND_DF_EN defined -> byte 6 = 40, checksum 77 62.
//  3 Two back-to-back packets -> second header bytes 4-5 = 00 01.
//    -> tx_start pulsed during the first packet is ignored.
//  4 tx_ready low for 5 cycles at header byte 7 and again at payload byte 3
//    -> the stream is unchanged apart from the stretch; payload_rd is 0 while stalled.
//  5 payload_len 1481 -> len_err pulse, busy stays 0.
//    payload_len 0, ICMP -> 20-byte header, proto 01, total length 00 14.
//  6 reset asserted at payload byte 2 -> next cycle out_valid=0, busy=0, ident=0.
//    A new tx_start then produces a complete header.

Source files
------------

// File: rtl/ip_send.sv
// Transmit-side IPv4 layer: builds a 20-byte header with its checksum and streams header + payload to the MAC.
// Optional feature: define IP_SEND_DF_EN to set the Don't Fragment flag (header byte 6 = 0x40).
module ip_send #(
  parameter logic [7:0]  TTL     = 8'd128,
  parameter logic [7:0]  TOS     = 8'd0,
  parameter logic [10:0] MAX_PAY = 11'd1480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_start,
  input  logic        is_icmp,
  input  logic [10:0] payload_len,
  input  logic [31:0] local_ip,
  input  logic [31:0] remote_ip,
  input  logic        tx_ready,
  input  logic [7:0]  payload_data,
  output logic        payload_rd,
  output logic [7:0]  data_out,
  output logic        out_valid,
  output logic        busy,
  output logic        len_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_CSUM, ST_HEADER, ST_PAYLOAD} state_t;

`ifdef IP_SEND_DF_EN
  localparam logic [7:0] FLAGS = 8'h40;
`else
  localparam logic [7:0] FLAGS = 8'h00;
`endif

  state_t      state_q;
  logic        busy_q, out_valid_q, len_err_q, icmp_q;
  logic [7:0]  data_q;
  logic [15:0] ident_q, csum_q;
  logic [10:0] len_q, cnt_q;
  logic [31:0] lip_q, rip_q;
  logic [4:0]  idx_q;
  logic [19:0] acc_q;

  logic [15:0] total_len_d, word_d;
  logic [7:0]  proto_d, hdr_next_d;
  logic [4:0]  idx_inc_d;
  logic        xfer_d;

  assign total_len_d = {5'd0, len_q} + 16'd20;
  assign proto_d     = icmp_q ? 8'h01 : 8'h11;
  assign idx_inc_d   = idx_q + 5'd1;
  assign xfer_d      = out_valid_q & tx_ready;

  // Header words as summed by the checksum; the checksum word itself counts as zero.
  always_comb begin
    word_d = 16'h0000;
    case (cnt_q[3:0])
      4'd0:    word_d = {8'h45, TOS};
      4'd1:    word_d = total_len_d;
      4'd2:    word_d = ident_q;
      4'd3:    word_d = {FLAGS, 8'h00};
      4'd4:    word_d = {TTL, proto_d};
      4'd6:    word_d = lip_q[31:16];
      4'd7:    word_d = lip_q[15:0];
      4'd8:    word_d = rip_q[31:16];
      4'd9:    word_d = rip_q[15:0];
      default: word_d = 16'h0000;
    endcase
  end

  always_comb begin
    hdr_next_d = 8'h00;
    case (idx_inc_d)
      5'd1:    hdr_next_d = TOS;
      5'd2:    hdr_next_d = total_len_d[15:8];
      5'd3:    hdr_next_d = total_len_d[7:0];
      5'd4:    hdr_next_d = ident_q[15:8];
      5'd5:    hdr_next_d = ident_q[7:0];
      5'd6:    hdr_next_d = FLAGS;
      5'd8:    hdr_next_d = TTL;
      5'd9:    hdr_next_d = proto_d;
      5'd10:   hdr_next_d = csum_q[15:8];
      5'd11:   hdr_next_d = csum_q[7:0];
      5'd12:   hdr_next_d = lip_q[31:24];
      5'd13:   hdr_next_d = lip_q[23:16];
      5'd14:   hdr_next_d = lip_q[15:8];
      5'd15:   hdr_next_d = lip_q[7:0];
      5'd16:   hdr_next_d = rip_q[31:24];
      5'd17:   hdr_next_d = rip_q[23:16];
      5'd18:   hdr_next_d = rip_q[15:8];
      5'd19:   hdr_next_d = rip_q[7:0];
      default: hdr_next_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      icmp_q      <= 1'b0;
      data_q      <= 8'h00;
      ident_q     <= 16'h0000;
      csum_q      <= 16'h0000;
      len_q       <= 11'd0;
      cnt_q       <= 11'd0;
      lip_q       <= 32'd0;
      rip_q       <= 32'd0;
      idx_q       <= 5'd0;
      acc_q       <= 20'd0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_start) begin
            if (payload_len > MAX_PAY) begin
              len_err_q <= 1'b1;
            end else begin
              icmp_q  <= is_icmp;
              len_q   <= payload_len;
              lip_q   <= local_ip;
              rip_q   <= remote_ip;
              busy_q  <= 1'b1;
              cnt_q   <= 11'd0;
              acc_q   <= 20'd0;
              state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          cnt_q <= cnt_q + 11'd1;
          if (cnt_q < 11'd10) begin
            acc_q <= acc_q + {4'd0, word_d};
          end else if (cnt_q == 11'd10) begin
            acc_q <= {4'd0, acc_q[15:0]} + {16'd0, acc_q[19:16]};
          end else if (cnt_q == 11'd11) begin
            csum_q <= ~(acc_q[15:0] + {12'd0, acc_q[19:16]});
          end else begin
            state_q     <= ST_HEADER;
            idx_q       <= 5'd0;
            data_q      <= 8'h45;
            out_valid_q <= 1'b1;
          end
        end
        ST_HEADER: begin
          if (xfer_d) begin
            if (idx_q == 5'd19) begin
              if (len_q == 11'd0) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                ident_q     <= ident_q + 16'd1;
              end else begin
                state_q <= ST_PAYLOAD;
                cnt_q   <= 11'd0;
              end
            end else begin
              idx_q  <= idx_inc_d;
              data_q <= hdr_next_d;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer_d) begin
            cnt_q <= cnt_q + 11'd1;
            if (cnt_q + 11'd1 == len_q) begin
              state_q     <= ST_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              ident_q     <= ident_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Payload bytes pass straight through so the upstream sender sees its read strobe in the same cycle.
  assign payload_rd = (state_q == ST_PAYLOAD) & tx_ready;
  assign data_out   = (state_q == ST_PAYLOAD) ? payload_data : data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_ip_send.sv
// Self-checking bench for ip_send: byte streams compared against a checksum/header model built from field values.
module tb_ip_send;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tx_start = 1'b0;
  logic        is_icmp = 1'b0;
  logic [10:0] payload_len = 11'd0;
  logic [31:0] local_ip = 32'd0;
  logic [31:0] remote_ip = 32'd0;
  logic        tx_ready = 1'b1;
  logic [7:0]  payload_data = 8'h00;
  logic        payload_rd, out_valid, busy, len_err;
  logic [7:0]  data_out;

  int total = 0;
  int bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pay[$];
  logic [15:0] model_ident = 16'h0000;

`ifdef IP_SEND_DF_EN
  localparam logic [7:0] DF_BYTE = 8'h40;
`else
  localparam logic [7:0] DF_BYTE = 8'h00;
`endif

  ip_send dut (
    .clock(clock), .reset(reset), .tx_start(tx_start), .is_icmp(is_icmp),
    .payload_len(payload_len), .local_ip(local_ip), .remote_ip(remote_ip),
    .tx_ready(tx_ready), .payload_data(payload_data), .payload_rd(payload_rd),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .len_err(len_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected packet: header words in network order, ones'-complement checksum, then random payload.
  task automatic build(input logic icmp, input logic [10:0] len, input logic [31:0] lip, input logic [31:0] rip);
    logic [15:0] w[10];
    int unsigned s;
    logic [7:0] b;
    exp_q.delete();
    pay.delete();
    w[0] = 16'h4500;
    w[1] = {5'd0, len} + 16'd20;
    w[2] = model_ident;
    w[3] = {DF_BYTE, 8'h00};
    w[4] = {8'd128, (icmp ? 8'h01 : 8'h11)};
    w[5] = 16'h0000;
    w[6] = lip[31:16];
    w[7] = lip[15:0];
    w[8] = rip[31:16];
    w[9] = rip[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += w[i];
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    w[5] = ~s[15:0];
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
    end
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      pay.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // mode 0: ready always; 1: random ready; 2: 5-cycle stalls at header byte 7 and payload byte 3.
  task automatic send(input logic icmp, input logic [10:0] len, input logic [31:0] lip,
                      input logic [31:0] rip, input int mode, input int spurious_at, input int abort_at);
    int got, ptr, cyc, first, stall_left, done;
    bit s7, s23;
    build(icmp, len, lip, rip);
    tx_start = 1'b1; is_icmp = icmp; payload_len = len; local_ip = lip; remote_ip = rip;
    got = 0; ptr = 0; cyc = 0; first = -1; stall_left = 0; done = 0; s7 = 0; s23 = 0;
    while (done == 0 && cyc < 4000) begin
      @(negedge clock);
      tx_start = (cyc == spurious_at);
      if (cyc == spurious_at) begin
        is_icmp = ~icmp; payload_len = len + 11'd3; local_ip = ~lip;
      end
      if (mode == 0) tx_ready = 1'b1;
      else if (mode == 1) tx_ready = ($urandom_range(0, 2) != 0);
      else begin
        if (got == 7 && !s7) begin stall_left = 5; s7 = 1; end
        if (got == 23 && !s23) begin stall_left = 5; s23 = 1; end
        tx_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      payload_data = (ptr < pay.size()) ? pay[ptr] : 8'h5A;
      #1;
      if (cyc == 0) check("busy_rise", {31'd0, busy}, 32'd1);
      if (abort_at >= 0 && got == abort_at) begin
        reset = 1'b1;
        @(negedge clock); #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tx_ready = 1'b1;
        model_ident = 16'h0000;
        return;
      end
      if (out_valid && first < 0) begin
        first = cyc;
        check("latency", cyc, 32'd13);
      end
      check("payload_rd", {31'd0, payload_rd},
            {31'd0, (tx_ready && out_valid && got >= 20 && got < exp_q.size())});
      if (out_valid) check($sformatf("byte%0d", got), {24'd0, data_out}, {24'd0, exp_q[got]});
      if (out_valid && tx_ready) got++;
      if (payload_rd) ptr++;
      if (got == exp_q.size()) done = 1;
      cyc++;
    end
    check("stream_done", done, 32'd1);
    tx_ready = 1'b1;
    @(negedge clock); #1;
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("valid_fall", {31'd0, out_valid}, 32'd0);
    check("pay_reads", ptr, {21'd0, len});
    model_ident = model_ident + 16'd1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rd", {31'd0, payload_rd}, 32'd0);
    check("rst_lenerr", {31'd0, len_err}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock); #1;

    send(1'b0, 11'd8, 32'hC0A8010A, 32'hC0A80114, 0, -1, -1);
    send(1'b0, 11'd8, 32'hC0A8010A, 32'hC0A80114, 0, 30, -1);
    send(1'b0, 11'd5, 32'h0A000001, 32'h0A000002, 0, 5, -1);
    send(1'b1, 11'd10, 32'h01020304, 32'hF0E0D0C0, 2, -1, -1);

    tx_start = 1'b1; payload_len = 11'd1481;
    @(negedge clock); #1;
    tx_start = 1'b0;
    check("len_err_pulse", {31'd0, len_err}, 32'd1);
    check("len_err_busy", {31'd0, busy}, 32'd0);
    @(negedge clock); #1;
    check("len_err_clear", {31'd0, len_err}, 32'd0);
    check("len_err_idle", {31'd0, busy}, 32'd0);

    send(1'b1, 11'd0, 32'hAC100001, 32'hAC1000FE, 0, -1, -1);
    send(1'b0, 11'd1480, 32'h7F000001, 32'h7F000002, 0, -1, -1);

    send(1'b0, 11'd6, 32'hC0A8010A, 32'hC0A80114, 0, -1, 22);
    send(1'b0, 11'd4, 32'hC0A8010A, 32'hC0A80114, 0, -1, -1);

    for (int k = 0; k < 6; k++)
      send(1'($urandom), 11'($urandom_range(0, 40)), $urandom, $urandom, 1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
